scandoubler: RTL and testbench

- Converts the 15 kHz PAL pixel stream (9-bit RGB plus composite sync) from the video generator into a 31 kHz line-doubled stream for VGA monitors.
- Sits downstream of the video block, on the same clock.
- The video stream arrives at half rate, qualified by a clock enable.
- Each captured input line is replayed twice at full clock rate from a ping-pong line buffer.

---
 rtl/scandoubler.sv | 95 +++++++++
 tb/tb_scandoubler.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scandoubler.sv
// Line doubler: captures each half-rate PAL line into a ping-pong buffer and
// replays the previous line twice at full clock rate for 31 kHz VGA timing.
module scandoubler #(
    parameter int LINE  = 448,
    parameter int HSYNC = 54,
    parameter int AW    = 9
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ce,
    input  logic       syncIn,
    input  logic [8:0] rgbIn,
    output logic [8:0] rgbOut,
    output logic [1:0] sync
);

    localparam logic [AW:0]   LINE_W = (AW+1)'(LINE);
    localparam logic [AW:0]   HS_W   = (AW+1)'(HSYNC);
    localparam logic [AW-1:0] LAST   = AW'(LINE - 1);
    localparam logic [AW-1:0] MID    = AW'(LINE / 2);

    logic [8:0]    lineBuf [0:(2**(AW+1))-1];

    logic [AW-1:0] hIn;
    logic [AW-1:0] hOut;
    logic          bank;
    logic          syncPrev;
    logic          vLow;
    logic          primed;
    logic          lineStart;
    logic          wrEn;
    logic [AW:0]   wrAddr;
    logic [AW:0]   rdAddr;

    assign lineStart = ce & syncPrev & ~syncIn;

    // The first pixel of a new line goes to address 0 of the bank about to
    // become the write bank, so it must be steered before the toggle lands.
    always_comb begin
        wrEn   = 1'b0;
        wrAddr = {bank, hIn};
        if (lineStart) begin
            wrEn   = 1'b1;
            wrAddr = {~bank, {AW{1'b0}}};
        end else if (ce && ({1'b0, hIn} < LINE_W)) begin
            wrEn   = 1'b1;
        end
    end

    assign rdAddr = {~bank, hOut};

    always_ff @(posedge clock) begin
        if (wrEn) begin
            lineBuf[wrAddr] <= rgbIn;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            hIn      <= '0;
            hOut     <= '0;
            bank     <= 1'b0;
            syncPrev <= 1'b1;
            vLow     <= 1'b0;
            primed   <= 1'b0;
            rgbOut   <= '0;
            sync     <= 2'b11;
        end else begin
            if (ce) begin
                syncPrev <= syncIn;
                if (lineStart) begin
                    hIn    <= AW'(1);
                    bank   <= ~bank;
                    primed <= 1'b1;
                end else if (hIn != '1) begin
                    hIn <= hIn + 1'b1;
                end
                if (hIn == MID) begin
                    vLow <= ~syncIn;
                end
            end

            if (lineStart || hOut == LAST) begin
                hOut <= '0;
            end else begin
                hOut <= hOut + 1'b1;
            end

            // Until a line has been captured the read bank holds nothing valid.
            rgbOut <= primed ? lineBuf[rdAddr] : '0;
            sync   <= {~vLow, ~({1'b0, hOut} < HS_W)};
        end
    end

endmodule

// File: tb/tb_scandoubler.sv
// Bench for scandoubler: line-level stimulus table plus a per-clock scoreboard
// of expected doubled pixels and hsync, with reset, vsync and ce corner cases.
module tb_scandoubler;

    localparam int LINE  = 448;
    localparam int HSYNC = 54;

    logic       clock = 1'b0;
    logic       reset;
    logic       ce;
    logic       syncIn;
    logic [8:0] rgbIn;
    logic [8:0] rgbOut;
    logic [1:0] sync;

    scandoubler #(.LINE(LINE), .HSYNC(HSYNC), .AW(9)) dut (
        .clock  (clock),
        .reset  (reset),
        .ce     (ce),
        .syncIn (syncIn),
        .rgbIn  (rgbIn),
        .rgbOut (rgbOut),
        .sync   (sync)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [8:0] rgb;
        logic       hs;
        bit         chkRgb;
        bit         chkHs;
    } expEntry_t;

    typedef struct {
        int len;
        int lowPix;
        int patt;
        bit expEarly;
        bit expMid;
    } lineVec_t;

    expEntry_t  q[$];
    lineVec_t   vecs[9];

    int errors = 0;
    int checks = 0;

    logic [8:0] mb [2][LINE];
    bit         mv [2][LINE];
    int         mbank;
    int         mh;
    bit         msp;
    int         kNext;

    bit         pendCe;
    bit         pendS;
    logic [8:0] pendD;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    function automatic logic [8:0] pixVal(input int patt, input int p);
        int v;
        v = p * (2 * patt + 1) + patt * 37;
        return v[8:0];
    endfunction

    task automatic modelReset();
        mbank = 0;
        mh    = 0;
        msp   = 1'b1;
        kNext = 1;
        q.delete();
    endtask

    task automatic pushReplay(input int n);
        expEntry_t e;
        int idx;
        for (int i = 0; i < n; i++) begin
            idx      = (kNext - 1) % LINE;
            e.rgb    = mb[mbank ^ 1][idx];
            e.hs     = (idx < HSYNC) ? 1'b0 : 1'b1;
            e.chkRgb = mv[mbank ^ 1][idx];
            e.chkHs  = 1'b1;
            q.push_back(e);
            kNext++;
        end
    endtask

    task automatic modelStep(input bit ceV, input bit s, input logic [8:0] d);
        expEntry_t keep;
        bit ls;
        if (!ceV) return;
        ls  = msp && !s;
        msp = s;
        if (ls) begin
            if (q.size() == 0) begin
                keep = '{rgb: 9'd0, hs: 1'b1, chkRgb: 1'b0, chkHs: 1'b0};
            end else begin
                keep = q[0];
            end
            q.delete();
            q.push_back(keep);
            mbank        = mbank ^ 1;
            mb[mbank][0] = d;
            mv[mbank][0] = 1'b1;
            mh           = 1;
            kNext        = 1;
            pushReplay(2 * LINE);
        end else begin
            if (mh < LINE) begin
                mb[mbank][mh] = d;
                mv[mbank][mh] = 1'b1;
            end
            if (mh < 511) mh++;
        end
    endtask

    // Inputs set here are sampled at the next edge; the model catches up one call later.
    task automatic cycle(input bit ceV, input bit s, input logic [8:0] d);
        @(posedge clock);
        #1;
        if (reset) modelStep(pendCe, pendS, pendD);
        ce     = ceV;
        syncIn = s;
        rgbIn  = d;
        pendCe = ceV;
        pendS  = s;
        pendD  = d;
    endtask

    task automatic driveLine(input int len, input int lowPix, input int patt,
                             input bit doVs, input bit expEarly, input bit expMid);
        bit s;
        for (int p = 0; p < len; p++) begin
            s = (p < lowPix) ? 1'b0 : 1'b1;
            cycle(1'b1, s, pixVal(patt, p));
            if (doVs && p == 100) check("vsyncEarly", int'(sync[1]), int'(expEarly));
            if (doVs && p == 230) check("vsyncMid", int'(sync[1]), int'(expMid));
            if (p == LINE) pushReplay(LINE);
            cycle(1'b0, s, 9'($urandom));
        end
    endtask

    always @(negedge clock) begin
        expEntry_t e;
        if (reset === 1'b1 && q.size() != 0) begin
            e = q.pop_front();
            if (e.chkRgb) check("rgbOut", int'(rgbOut), int'(e.rgb));
            if (e.chkHs)  check("hsync", int'(sync[0]), int'(e.hs));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int hsBad;
        int rgbBad;
        int vsBad;
        int expHs;

        vecs[0] = '{len: 448, lowPix: 32,  patt: 0, expEarly: 1'b1, expMid: 1'b1};
        vecs[1] = '{len: 448, lowPix: 32,  patt: 1, expEarly: 1'b1, expMid: 1'b1};
        vecs[2] = '{len: 448, lowPix: 444, patt: 2, expEarly: 1'b1, expMid: 1'b0};
        vecs[3] = '{len: 448, lowPix: 444, patt: 3, expEarly: 1'b0, expMid: 1'b0};
        vecs[4] = '{len: 448, lowPix: 32,  patt: 4, expEarly: 1'b0, expMid: 1'b1};
        vecs[5] = '{len: 300, lowPix: 32,  patt: 5, expEarly: 1'b1, expMid: 1'b1};
        vecs[6] = '{len: 448, lowPix: 32,  patt: 6, expEarly: 1'b1, expMid: 1'b1};
        vecs[7] = '{len: 600, lowPix: 32,  patt: 7, expEarly: 1'b1, expMid: 1'b1};
        vecs[8] = '{len: 448, lowPix: 32,  patt: 8, expEarly: 1'b1, expMid: 1'b1};

        for (int b = 0; b < 2; b++)
            for (int a = 0; a < LINE; a++) begin
                mb[b][a] = '0;
                mv[b][a] = 1'b0;
            end

        reset  = 1'b0;
        ce     = 1'b0;
        syncIn = 1'b1;
        rgbIn  = '0;
        pendCe = 1'b0;
        pendS  = 1'b1;
        pendD  = '0;
        modelReset();
        repeat (3) @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b1;

        // Stream two lines, then yank reset while hsync is low mid-replay.
        driveLine(448, 32, 9, 1'b0, 1'b0, 1'b0);
        driveLine(10, 32, 10, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #3;
        check("preResetHsync", int'(sync[0]), 0);
        reset = 1'b0;
        #1;
        check("resetRgb", int'(rgbOut), 0);
        check("resetSync", int'(sync), 3);
        q.delete();
        repeat (3) @(posedge clock);
        @(posedge clock);
        #1;
        reset  = 1'b1;
        ce     = 1'b0;
        syncIn = 1'b1;
        pendCe = 1'b0;
        modelReset();

        // Free-running output before any lineStart: blank pixels, hsync every 448.
        hsBad  = 0;
        rgbBad = 0;
        vsBad  = 0;
        for (int c = 1; c <= 2 * LINE; c++) begin
            cycle(c % 2 == 1, 1'b1, 9'($urandom));
            expHs = (((c - 1) % LINE) < HSYNC) ? 0 : 1;
            if (int'(sync[0]) != expHs) hsBad++;
            if (rgbOut != 9'd0) rgbBad++;
            if (sync[1] != 1'b1) vsBad++;
        end
        check("idleHsyncMismatches", hsBad, 0);
        check("idleRgbNonzero", rgbBad, 0);
        check("idleVsyncLow", vsBad, 0);

        for (int i = 0; i < 9; i++) begin
            driveLine(vecs[i].len, vecs[i].lowPix, vecs[i].patt, 1'b1,
                      vecs[i].expEarly, vecs[i].expMid);
        end

        // Sync pulse only on a ce=0 clock must not start a line.
        for (int p = 0; p < LINE; p++) begin
            cycle(1'b1, 1'b1, 9'($urandom));
            cycle(1'b0, (p == 200) ? 1'b0 : 1'b1, 9'($urandom));
        end

        for (int i = 0; i < 2000 && q.size() != 0; i++) @(posedge clock);
        check("scoreboardDrained", q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
